ysyx_rnu_ctrl: RTL and testbench
================================

Name: ysyx_rnu_ctrl

Overview:
- Rename-stage sequencer for the RNU. Drives the free list and the map table master ports.
- Accepts one decoded instruction per cycle and reads its rs1, rs2 and old-rd mappings.
- Allocates a physical rd, writes the speculative map and presents the renamed result to dispatch through a one-entry output register.
- Applies ROB commits to the committed RAT and returns freed PRs to the free list.
- Sequences flush recovery: a map-table restore pulse, then a walk of the free list over every architectural register.

Parameters:
- PLEN, `YSYX_PHY_LEN, physical register index width.
- RLEN, `YSYX_REG_LEN, architectural register index width. Walk length is 2^RLEN-1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, active low.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  rename can accept.
- in_wen  in  1  instruction writes rd.
- in_rd, in_rs1, in_rs2  in  RLEN each  architectural indices.
- out_valid  out  1  renamed instruction valid.
- out_ready  in  1  dispatch accepts.
- out_wen  out  1  registered in_wen, forced to 0 when rd=0.
- out_prd, out_prs1, out_prs2, out_prd_old  out  PLEN each  renamed indices.
- cmt_valid  in  1  ROB commit this cycle.
- cmt_wen  in  1  committed instruction writes rd.
- cmt_rd  in  RLEN  committed rd.
- cmt_prd  in  PLEN  committed new PR.
- cmt_prd_old  in  PLEN  committed old PR, to be freed.
- flush  in  1  pipeline flush from commit.
- busy  out  1  recovery in progress.
- fl_flush_pipe  out  1  free-list recovery strobe.
- fl_flush_rd  out  RLEN  register being walked.
- fl_alloc_req  out  1  allocate request.
- fl_alloc_pr  in  PLEN  PR that will be allocated.
- fl_alloc_empty  in  1  no free PR.
- fl_dealloc_req  out  1  free request.
- fl_dealloc_pr  out  PLEN  PR to free.
- mt_flush_pipe  out  1  restore MAP from RAT.
- mt_map_wen  out  1  speculative map write enable.
- mt_map_waddr  out  RLEN  speculative map write address.
- mt_map_wdata  out  PLEN  speculative map write data.
- mt_map_raddr_a, mt_map_raddr_b, mt_map_raddr_c  out  RLEN each  read addresses (rs1, rs2, old rd).
- mt_map_rdata_a, mt_map_rdata_b, mt_map_rdata_c  in  PLEN each  read data, combinational.
- mt_rat_wen  out  1  committed RAT write enable.
- mt_rat_waddr  out  RLEN  committed RAT write address.
- mt_rat_wdata  out  PLEN  committed RAT write data.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=RUN.
  - out_valid=0 and all out_* fields 0.
  - busy=0, fl_flush_pipe=0, fl_flush_rd=0, mt_flush_pipe=0.
  - All request and write enables 0.
  - Reset mid-recovery aborts the walk.
- States: RUN and RECOVER.
- Read addresses:
  - mt_map_raddr_a/b/c = in_rs1/in_rs2/in_rd, combinational.
  - Read data is sampled on fire.
- need_alloc = in_wen && in_rd!=0.
- in_ready = (state==RUN) && !flush && (!out_valid || out_ready) && !(need_alloc && fl_alloc_empty).
- fire = in_valid && in_ready.
- On fire:
  - fl_alloc_req = need_alloc.
  - mt_map_wen = need_alloc, mt_map_waddr = in_rd, mt_map_wdata = fl_alloc_pr, all in the same cycle.
  - Next cycle: out_valid=1 with prs1 = rdata_a, prs2 = rdata_b, prd_old = rdata_c.
  - prd = fl_alloc_pr, or 0 when !need_alloc.
  - out_wen = need_alloc.
- rs1/rs2 of x0 pass through whatever the map table returns for index 0, which is always 0.
- Back-to-back dependent instructions are correct with no bypass, because the map write lands before the next read.
- Output register:
  - Holds its value while out_valid && !out_ready.
  - Clears when out_ready is high and there is no fire.
  - Never drops or duplicates an entry.
- Commit, processed in RUN and in the flush cycle:
  - Condition: cmt_valid && cmt_wen && cmt_rd!=0.
  - mt_rat_wen=1, rat_waddr = cmt_rd, rat_wdata = cmt_prd.
  - fl_dealloc_req=1, dealloc_pr = cmt_prd_old.
  - Combinational, same cycle.
- Flush:
  - In the flush cycle: fire is suppressed, mt_flush_pipe=1 for exactly that cycle, and the commit above still applies.
  - Next cycle: out_valid=0, state=RECOVER, walk counter=1.
- RECOVER:
  - busy=1, fl_flush_pipe=1, fl_flush_rd = counter.
  - Counter increments by 1 each cycle.
  - When the counter reaches 2^RLEN-1, that cycle is the last walk cycle. state=RUN next cycle.
  - The walk lasts exactly 2^RLEN-1 cycles; no wrap to 0.
  - in_ready=0 throughout.
- flush during RECOVER:
  - mt_flush_pipe pulses again.
  - The counter restarts at 1 next cycle.
- cmt_valid in RECOVER is illegal: it is ignored and triggers a simulation assertion.
- fl_alloc_empty with need_alloc stalls the input only; the output register and commits are unaffected.

Test Plan:
- Reset released, in_valid=1, in_wen=1, rd=5, rs1=1, rs2=2, alloc_pr=40, rdata_a=1, rdata_b=2, rdata_c=5 -> same cycle: alloc_req=1, map_wen=1, waddr=5, wdata=40. Next cycle: out_valid=1, prd=40, prs1=1, prs2=2, prd_old=5.
- rd=0 with in_wen=1 -> alloc_req=0, map_wen=0. Output out_wen=0, prd=0.
- out_ready=0 for 3 cycles with in_valid held -> in_ready=0 and out_* stable. out_ready=1 -> handoff, next instruction accepted the same cycle.
- fl_alloc_empty=1 with need_alloc -> in_ready=0. An instruction with in_wen=0 is still accepted.
- cmt_valid=1, wen=1, rd=7, prd=33, prd_old=12 -> rat_wen=1, waddr=7, wdata=33, dealloc_req=1, dealloc_pr=12.
- flush while out_valid=1 -> mt_flush_pipe pulses 1 cycle and out_valid drops. busy=1 with fl_flush_rd = 1..31 over 31 cycles (RLEN=5). A second flush at rd=10 restarts the walk at 1. Reset low mid-walk -> busy=0 next cycle.

Source files
------------

// File: rtl/ysyx_rnu_ctrl.sv
// Rename-stage sequencer: allocates physical rd, updates speculative map,
// applies commits to the RAT and walks the free list after a flush.
`ifndef YSYX_PHY_LEN
`define YSYX_PHY_LEN 6
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

module ysyx_rnu_ctrl #(
  parameter int PLEN = `YSYX_PHY_LEN,
  parameter int RLEN = `YSYX_REG_LEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_wen,
  input  logic [RLEN-1:0] in_rd,
  input  logic [RLEN-1:0] in_rs1,
  input  logic [RLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_wen,
  output logic [PLEN-1:0] out_prd,
  output logic [PLEN-1:0] out_prs1,
  output logic [PLEN-1:0] out_prs2,
  output logic [PLEN-1:0] out_prd_old,
  input  logic            cmt_valid,
  input  logic            cmt_wen,
  input  logic [RLEN-1:0] cmt_rd,
  input  logic [PLEN-1:0] cmt_prd,
  input  logic [PLEN-1:0] cmt_prd_old,
  input  logic            flush,
  output logic            busy,
  output logic            fl_flush_pipe,
  output logic [RLEN-1:0] fl_flush_rd,
  output logic            fl_alloc_req,
  input  logic [PLEN-1:0] fl_alloc_pr,
  input  logic            fl_alloc_empty,
  output logic            fl_dealloc_req,
  output logic [PLEN-1:0] fl_dealloc_pr,
  output logic            mt_flush_pipe,
  output logic            mt_map_wen,
  output logic [RLEN-1:0] mt_map_waddr,
  output logic [PLEN-1:0] mt_map_wdata,
  output logic [RLEN-1:0] mt_map_raddr_a,
  output logic [RLEN-1:0] mt_map_raddr_b,
  output logic [RLEN-1:0] mt_map_raddr_c,
  input  logic [PLEN-1:0] mt_map_rdata_a,
  input  logic [PLEN-1:0] mt_map_rdata_b,
  input  logic [PLEN-1:0] mt_map_rdata_c,
  output logic            mt_rat_wen,
  output logic [RLEN-1:0] mt_rat_waddr,
  output logic [PLEN-1:0] mt_rat_wdata
);

  // state   | meaning
  // RUN     | rename one instruction per cycle, apply commits
  // RECOVER | walk the free list over x1 .. x(2^RLEN-1) after a flush
  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_RECOVER = 1'b1;

  logic [0:0]      state;
  logic [RLEN-1:0] walk_cnt;
  logic            run;
  logic            need_alloc;
  logic            fire;
  logic            cmt_ok;

  assign run        = (state == S_RUN);
  assign need_alloc = in_wen && (in_rd != '0);
  assign in_ready   = run && !flush && (!out_valid || out_ready)
                      && !(need_alloc && fl_alloc_empty);
  assign fire       = in_valid && in_ready;

  assign mt_map_raddr_a = in_rs1;
  assign mt_map_raddr_b = in_rs2;
  assign mt_map_raddr_c = in_rd;

  assign fl_alloc_req = fire && need_alloc;
  assign mt_map_wen   = fire && need_alloc;
  assign mt_map_waddr = in_rd;
  assign mt_map_wdata = fl_alloc_pr;

  // Commits are only legal in RUN; the flush cycle itself is still RUN.
  assign cmt_ok         = run && cmt_valid && cmt_wen && (cmt_rd != '0);
  assign mt_rat_wen     = cmt_ok;
  assign mt_rat_waddr   = cmt_rd;
  assign mt_rat_wdata   = cmt_prd;
  assign fl_dealloc_req = cmt_ok;
  assign fl_dealloc_pr  = cmt_prd_old;

  assign mt_flush_pipe = flush;
  assign busy          = !run;
  assign fl_flush_pipe = !run;
  assign fl_flush_rd   = walk_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_RUN;
      walk_cnt <= '0;
    end else if (flush) begin
      state    <= S_RECOVER;
      walk_cnt <= RLEN'(1);
    end else if (state == S_RECOVER) begin
      if (walk_cnt == {RLEN{1'b1}}) begin
        state    <= S_RUN;
        walk_cnt <= '0;
      end else begin
        walk_cnt <= walk_cnt + RLEN'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      out_valid   <= 1'b0;
      out_wen     <= 1'b0;
      out_prd     <= '0;
      out_prs1    <= '0;
      out_prs2    <= '0;
      out_prd_old <= '0;
    end else if (fire) begin
      out_valid   <= 1'b1;
      out_wen     <= need_alloc;
      out_prd     <= need_alloc ? fl_alloc_pr : '0;
      out_prs1    <= mt_map_rdata_a;
      out_prs2    <= mt_map_rdata_b;
      out_prd_old <= mt_map_rdata_c;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
      out_wen     <= 1'b0;
      out_prd     <= '0;
      out_prs1    <= '0;
      out_prs2    <= '0;
      out_prd_old <= '0;
    end
  end

  a_no_cmt_in_recover: assert property (@(posedge clock) disable iff (!reset)
    (state == S_RECOVER) |-> !cmt_valid);

endmodule

// File: tb/tb_ysyx_rnu_ctrl.sv
// Bench for ysyx_rnu_ctrl: directed vector table, flush/walk sequences,
// and randomized traffic against a map-array reference model.
module tb_ysyx_rnu_ctrl;
  localparam int PLEN = 6;
  localparam int RLEN = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, in_wen;
  logic [RLEN-1:0] in_rd, in_rs1, in_rs2;
  logic            out_valid, out_ready, out_wen;
  logic [PLEN-1:0] out_prd, out_prs1, out_prs2, out_prd_old;
  logic            cmt_valid, cmt_wen;
  logic [RLEN-1:0] cmt_rd;
  logic [PLEN-1:0] cmt_prd, cmt_prd_old;
  logic            flush, busy, fl_flush_pipe;
  logic [RLEN-1:0] fl_flush_rd;
  logic            fl_alloc_req, fl_alloc_empty, fl_dealloc_req;
  logic [PLEN-1:0] fl_alloc_pr, fl_dealloc_pr;
  logic            mt_flush_pipe, mt_map_wen, mt_rat_wen;
  logic [RLEN-1:0] mt_map_waddr, mt_map_raddr_a, mt_map_raddr_b, mt_map_raddr_c, mt_rat_waddr;
  logic [PLEN-1:0] mt_map_wdata, mt_map_rdata_a, mt_map_rdata_b, mt_map_rdata_c, mt_rat_wdata;

  // Environment map table: identity at init, written by the DUT's map port.
  logic [PLEN-1:0] map [32];
  logic            map_init;
  always @(posedge clock) begin
    if (map_init) begin
      for (int i = 0; i < 32; i++) map[i] <= PLEN'(i);
    end else if (mt_map_wen) begin
      map[mt_map_waddr] <= mt_map_wdata;
    end
  end
  assign mt_map_rdata_a = map[mt_map_raddr_a];
  assign mt_map_rdata_b = map[mt_map_raddr_b];
  assign mt_map_rdata_c = map[mt_map_raddr_c];

  always #5 clock = ~clock;

  ysyx_rnu_ctrl #(.PLEN(PLEN), .RLEN(RLEN)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_wen(out_wen),
    .out_prd(out_prd), .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd_old(out_prd_old),
    .cmt_valid(cmt_valid), .cmt_wen(cmt_wen), .cmt_rd(cmt_rd),
    .cmt_prd(cmt_prd), .cmt_prd_old(cmt_prd_old),
    .flush(flush), .busy(busy), .fl_flush_pipe(fl_flush_pipe), .fl_flush_rd(fl_flush_rd),
    .fl_alloc_req(fl_alloc_req), .fl_alloc_pr(fl_alloc_pr), .fl_alloc_empty(fl_alloc_empty),
    .fl_dealloc_req(fl_dealloc_req), .fl_dealloc_pr(fl_dealloc_pr),
    .mt_flush_pipe(mt_flush_pipe), .mt_map_wen(mt_map_wen),
    .mt_map_waddr(mt_map_waddr), .mt_map_wdata(mt_map_wdata),
    .mt_map_raddr_a(mt_map_raddr_a), .mt_map_raddr_b(mt_map_raddr_b),
    .mt_map_raddr_c(mt_map_raddr_c),
    .mt_map_rdata_a(mt_map_rdata_a), .mt_map_rdata_b(mt_map_rdata_b),
    .mt_map_rdata_c(mt_map_rdata_c),
    .mt_rat_wen(mt_rat_wen), .mt_rat_waddr(mt_rat_waddr), .mt_rat_wdata(mt_rat_wdata)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    int iv, iw, rd, rs1, rs2, apr, ae, ordy;
    int cv, cw, crd, cprd, cold;
    int e_ready, e_alloc, e_rat, e_dpr;
    int e_ov, e_ow, e_prd, e_p1, e_p2, e_pold;
  } vec_t;

  vec_t vt[11];

  task automatic idle_inputs();
    in_valid = 0; in_wen = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
    out_ready = 1; cmt_valid = 0; cmt_wen = 0; cmt_rd = 0; cmt_prd = 0; cmt_prd_old = 0;
    flush = 0; fl_alloc_pr = 0; fl_alloc_empty = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0; map_init = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1; map_init = 0;
  endtask

  task automatic apply(input vec_t v);
    in_valid = v.iv[0]; in_wen = v.iw[0]; in_rd = RLEN'(v.rd);
    in_rs1 = RLEN'(v.rs1); in_rs2 = RLEN'(v.rs2); fl_alloc_pr = PLEN'(v.apr);
    fl_alloc_empty = v.ae[0]; out_ready = v.ordy[0];
    cmt_valid = v.cv[0]; cmt_wen = v.cw[0]; cmt_rd = RLEN'(v.crd);
    cmt_prd = PLEN'(v.cprd); cmt_prd_old = PLEN'(v.cold);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // reference model state
  int m_ov, m_ow, m_prd, m_p1, m_p2, m_pold;
  int mm[32];

  initial begin
    int exp_rd;
    bit restarted;
    vec_t v;

    vt[0]  = '{1,1,5,1,2,40,0,1,   0,0,0,0,0,      1,1,0,0,   1,1,40,1,2,5};
    vt[1]  = '{1,1,0,5,3,41,0,1,   0,0,0,0,0,      1,0,0,0,   1,0,0,40,3,0};
    vt[2]  = '{1,1,6,5,0,42,0,0,   0,0,0,0,0,      0,0,0,0,   1,0,0,40,3,0};
    vt[3]  = vt[2];
    vt[4]  = vt[2];
    vt[5]  = '{1,1,6,5,0,42,0,1,   0,0,0,0,0,      1,1,0,0,   1,1,42,40,0,6};
    vt[6]  = '{1,1,7,6,1,43,1,1,   1,1,7,33,12,    0,0,1,12,  0,0,0,0,0,0};
    vt[7]  = '{1,0,7,6,5,43,1,1,   0,0,0,0,0,      1,0,0,0,   1,0,0,42,40,7};
    vt[8]  = '{0,0,0,0,0,0,0,1,    1,1,0,9,3,      1,0,0,0,   0,0,0,0,0,0};
    vt[9]  = '{1,1,31,31,7,63,0,0, 1,1,31,50,31,   1,1,1,31,  1,1,63,31,7,31};
    vt[10] = '{0,0,0,0,0,0,0,1,    1,0,4,9,9,      1,0,0,0,   0,0,0,0,0,0};

    do_reset();
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_prd", int'(out_prd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fl_flush_pipe", int'(fl_flush_pipe), 0);
    chk("rst_fl_flush_rd", int'(fl_flush_rd), 0);
    chk("rst_mt_flush_pipe", int'(mt_flush_pipe), 0);
    chk("rst_alloc_req", int'(fl_alloc_req), 0);
    chk("rst_rat_wen", int'(mt_rat_wen), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      v = vt[i];
      apply(v);
      #1;
      chk($sformatf("v%0d_in_ready", i), int'(in_ready), v.e_ready);
      chk($sformatf("v%0d_alloc_req", i), int'(fl_alloc_req), v.e_alloc);
      chk($sformatf("v%0d_map_wen", i), int'(mt_map_wen), v.e_alloc);
      if (v.e_alloc != 0) begin
        chk($sformatf("v%0d_map_waddr", i), int'(mt_map_waddr), v.rd);
        chk($sformatf("v%0d_map_wdata", i), int'(mt_map_wdata), v.apr);
      end
      chk($sformatf("v%0d_rat_wen", i), int'(mt_rat_wen), v.e_rat);
      chk($sformatf("v%0d_dealloc_req", i), int'(fl_dealloc_req), v.e_rat);
      if (v.e_rat != 0) begin
        chk($sformatf("v%0d_rat_waddr", i), int'(mt_rat_waddr), v.crd);
        chk($sformatf("v%0d_rat_wdata", i), int'(mt_rat_wdata), v.cprd);
        chk($sformatf("v%0d_dealloc_pr", i), int'(fl_dealloc_pr), v.e_dpr);
      end
      step();
      chk($sformatf("v%0d_out_valid", i), int'(out_valid), v.e_ov);
      if (v.e_ov != 0) begin
        chk($sformatf("v%0d_out_wen", i), int'(out_wen), v.e_ow);
        chk($sformatf("v%0d_out_prd", i), int'(out_prd), v.e_prd);
        chk($sformatf("v%0d_out_prs1", i), int'(out_prs1), v.e_p1);
        chk($sformatf("v%0d_out_prs2", i), int'(out_prs2), v.e_p2);
        chk($sformatf("v%0d_out_prd_old", i), int'(out_prd_old), v.e_pold);
      end
    end

    // flush with a valid output and a commit in the same cycle
    idle_inputs();
    in_valid = 1; in_wen = 1; in_rd = 3; in_rs1 = 1; in_rs2 = 2; fl_alloc_pr = 20; out_ready = 0;
    step();
    chk("pre_flush_out_valid", int'(out_valid), 1);
    flush = 1; cmt_valid = 1; cmt_wen = 1; cmt_rd = 7; cmt_prd = 33; cmt_prd_old = 12;
    #1;
    chk("flush_in_ready", int'(in_ready), 0);
    chk("flush_alloc_req", int'(fl_alloc_req), 0);
    chk("flush_mt_flush_pipe", int'(mt_flush_pipe), 1);
    chk("flush_rat_wen", int'(mt_rat_wen), 1);
    chk("flush_dealloc_pr", int'(fl_dealloc_pr), 12);
    chk("flush_busy", int'(busy), 0);
    step();
    flush = 0; cmt_valid = 0; cmt_wen = 0; in_rd = 4;
    #1;
    chk("post_flush_pulse", int'(mt_flush_pipe), 0);
    chk("post_flush_out_valid", int'(out_valid), 0);

    // walk 1..31, re-flushed at 10, bounded to 50 cycles
    exp_rd = 1;
    restarted = 0;
    for (int c = 0; c < 50 && exp_rd != 0; c++) begin
      chk("walk_busy", int'(busy), 1);
      chk("walk_fl_flush_pipe", int'(fl_flush_pipe), 1);
      chk("walk_fl_flush_rd", int'(fl_flush_rd), exp_rd);
      chk("walk_in_ready", int'(in_ready), 0);
      chk("walk_alloc_req", int'(fl_alloc_req), 0);
      if (exp_rd == 10 && !restarted) begin
        flush = 1;
        #1;
        chk("walk_reflush_pulse", int'(mt_flush_pipe), 1);
        restarted = 1;
        exp_rd = 1;
      end else begin
        exp_rd = (exp_rd == 31) ? 0 : exp_rd + 1;
      end
      step();
      flush = 0;
      #1;
    end
    chk("walk_completed", exp_rd, 0);
    in_valid = 0;
    #1;
    chk("walk_end_busy", int'(busy), 0);
    chk("walk_end_fl_flush_rd", int'(fl_flush_rd), 0);
    chk("walk_end_in_ready", int'(in_ready), 1);

    // reset in the middle of a walk
    flush = 1;
    step();
    flush = 0;
    repeat (3) step();
    chk("midwalk_busy", int'(busy), 1);
    reset = 0;
    step();
    chk("rst_midwalk_busy", int'(busy), 0);
    chk("rst_midwalk_fl_flush_pipe", int'(fl_flush_pipe), 0);
    chk("rst_midwalk_fl_flush_rd", int'(fl_flush_rd), 0);
    reset = 1;

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 32; i++) mm[i] = i;
    m_ov = 0; m_ow = 0; m_prd = 0; m_p1 = 0; m_p2 = 0; m_pold = 0;
    for (int c = 0; c < 1000; c++) begin
      int need, rdy, fr, rat, rd, rs1, rs2, apr, ordy, rv1, rv2, rv3;
      in_valid = ($urandom % 4) != 0;
      in_wen = $urandom % 2;
      rd = ($urandom % 5 == 0) ? 0 : int'($urandom % 32);
      rs1 = $urandom % 32; rs2 = $urandom % 32; apr = $urandom % 64;
      ordy = ($urandom % 3) != 0;
      in_rd = RLEN'(rd); in_rs1 = RLEN'(rs1); in_rs2 = RLEN'(rs2);
      fl_alloc_pr = PLEN'(apr);
      fl_alloc_empty = ($urandom % 8) == 0;
      out_ready = ordy[0];
      cmt_valid = $urandom % 2; cmt_wen = $urandom % 2;
      cmt_rd = RLEN'($urandom % 32); cmt_prd = PLEN'($urandom % 64); cmt_prd_old = PLEN'($urandom % 64);
      #1;
      need = (in_wen && rd != 0) ? 1 : 0;
      rdy = ((m_ov == 0 || ordy != 0) && !(need != 0 && fl_alloc_empty)) ? 1 : 0;
      fr = (in_valid && rdy != 0) ? 1 : 0;
      rat = (cmt_valid && cmt_wen && cmt_rd != 0) ? 1 : 0;
      chk("rnd_in_ready", int'(in_ready), rdy);
      chk("rnd_alloc_req", int'(fl_alloc_req), fr & need);
      chk("rnd_map_wen", int'(mt_map_wen), fr & need);
      if ((fr & need) != 0) chk("rnd_map_wdata", int'(mt_map_wdata), apr);
      chk("rnd_rat_wen", int'(mt_rat_wen), rat);
      chk("rnd_dealloc_req", int'(fl_dealloc_req), rat);
      if (rat != 0) begin
        chk("rnd_rat_wdata", int'(mt_rat_wdata), int'(cmt_prd));
        chk("rnd_dealloc_pr", int'(fl_dealloc_pr), int'(cmt_prd_old));
      end
      chk("rnd_out_valid", int'(out_valid), m_ov);
      if (m_ov != 0) begin
        chk("rnd_out_wen", int'(out_wen), m_ow);
        chk("rnd_out_prd", int'(out_prd), m_prd);
        chk("rnd_out_prs1", int'(out_prs1), m_p1);
        chk("rnd_out_prs2", int'(out_prs2), m_p2);
        chk("rnd_out_prd_old", int'(out_prd_old), m_pold);
      end
      rv1 = mm[rs1]; rv2 = mm[rs2]; rv3 = mm[rd];
      if (fr != 0) begin
        m_ov = 1; m_ow = need; m_prd = (need != 0) ? apr : 0;
        m_p1 = rv1; m_p2 = rv2; m_pold = rv3;
        if (need != 0) mm[rd] = apr;
      end else if (ordy != 0) begin
        m_ov = 0;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
